hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_pkg.sv | 16 +
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions used by the hazard controller and its neighbours.
package cpu_pkg;

   // The hazard controller is either passing instructions or holding ID for a mul/div.
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MD_WAIT = 1'b1
   } hz_state_t;

   // Default number of cycles a multiply/divide holds the ID stage.
   localparam int MD_CYCLES_DEF = 8;

   // Register index 0 is hard-wired to zero and never creates a dependence.
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle mul/div stalls,
// taken-branch flushes and a saturating count of PC-stall cycles.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int MD_CYCLES = MD_CYCLES_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_read_ex,
   input  logic [4:0]  rt_ex,
   input  logic [4:0]  rs_id,
   input  logic [4:0]  rt_id,
   input  logic        uses_rt_id,
   input  logic        branch_taken_ex,
   input  logic        md_start_id,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        ID_EXE_flush,
   output logic        md_busy,
   output logic [15:0] stall_count
);

   // The entry cycle in IDLE is the first stall cycle, so MD_WAIT covers the rest.
   localparam logic [7:0] MD_CNT_LOAD = 8'(MD_CYCLES - 2);

   hz_state_t  state;
   hz_state_t  next_state;
   logic [7:0] md_cnt;
   logic [7:0] next_cnt;
   logic       load_use;

   // A load in EX feeding a source register of the instruction in ID.
   assign load_use = mem_read_ex && (rt_ex != REG_ZERO) &&
                     ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));

   // Prioritised control outputs and next-state selection.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      ID_EXE_flush = 1'b0;
      md_busy      = 1'b0;
      next_state   = state;
      next_cnt     = md_cnt;
      if (!reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         ID_EXE_flush = 1'b1;
         next_state   = IDLE;
         next_cnt     = 8'd0;
      end else if (branch_taken_ex) begin
         if_id_flush  = 1'b1;
         ID_EXE_flush = 1'b1;
         next_state   = IDLE;
         next_cnt     = 8'd0;
      end else if (state == MD_WAIT) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         ID_EXE_flush = 1'b1;
         md_busy      = 1'b1;
         if (md_cnt == 8'd0) begin
            next_state = IDLE;
         end else begin
            next_cnt = md_cnt - 8'd1;
         end
      end else if (load_use) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         ID_EXE_flush = 1'b1;
      end else if (md_start_id) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         ID_EXE_flush = 1'b1;
         md_busy      = 1'b1;
         next_state   = MD_WAIT;
         next_cnt     = MD_CNT_LOAD;
      end
   end

   // State, mul/div countdown and saturating stall counter.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= IDLE;
         md_cnt      <= 8'd0;
         stall_count <= 16'd0;
      end else begin
         state  <= next_state;
         md_cnt <= next_cnt;
         if (!pc_write && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle sequences,
// with expected outputs queued at drive time and compared before the next edge.
module tb_hazard_ctrl;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_exe_flush;
      logic md_busy;
   } exp_t;

   typedef struct {
      logic       rst;
      logic       ml;
      logic [4:0] rte;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urt;
      logic       br;
      logic       md;
   } stim_t;

   typedef struct {
      stim_t s;
      exp_t  e;
      string name;
   } vec_t;

   localparam exp_t NORMAL  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam exp_t STALL_LU = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam exp_t STALL_MD = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam exp_t BRANCH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam exp_t RESET_O = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   logic        clock;
   logic        reset;
   logic        mem_read_ex;
   logic [4:0]  rt_ex;
   logic [4:0]  rs_id;
   logic [4:0]  rt_id;
   logic        uses_rt_id;
   logic        branch_taken_ex;
   logic        md_start_id;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        ID_EXE_flush;
   logic        md_busy;
   logic [15:0] stall_count;

   int          tests_run;
   int          tests_failed;
   logic [15:0] exp_count;

   exp_t        exp_q[$];
   string       name_q[$];
   logic        rst_q[$];

   vec_t        vecs[13];

   hazard_ctrl #(.MD_CYCLES(8)) dut (
      .clock           (clock),
      .reset           (reset),
      .mem_read_ex     (mem_read_ex),
      .rt_ex           (rt_ex),
      .rs_id           (rs_id),
      .rt_id           (rt_id),
      .uses_rt_id      (uses_rt_id),
      .branch_taken_ex (branch_taken_ex),
      .md_start_id     (md_start_id),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .ID_EXE_flush    (ID_EXE_flush),
      .md_busy         (md_busy),
      .stall_count     (stall_count)
   );

   // 10-unit pipeline clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic stim_t mk(input logic rst, input logic ml, input logic [4:0] rte,
                                input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                                input logic br, input logic md);
      stim_t s;
      s.rst = rst; s.ml = ml; s.rte = rte; s.rs = rs; s.rt = rt;
      s.urt = urt; s.br = br; s.md = md;
      return s;
   endfunction

   // Drive one cycle of inputs just after the falling edge and queue its expectation.
   task automatic applyStimulus(input stim_t s, input exp_t e, input string name);
      @(negedge clock);
      reset           = s.rst;
      mem_read_ex     = s.ml;
      rt_ex           = s.rte;
      rs_id           = s.rs;
      rt_id           = s.rt;
      uses_rt_id      = s.urt;
      branch_taken_ex = s.br;
      md_start_id     = s.md;
      exp_q.push_back(e);
      name_q.push_back(name);
      rst_q.push_back(s.rst);
   endtask

   // Compare the settled outputs against the oldest queued expectation, then
   // advance the stall-count model for the coming rising edge.
   task automatic checkOutput();
      exp_t  e;
      exp_t  got;
      string name;
      logic  rst;
      #2;
      e    = exp_q.pop_front();
      name = name_q.pop_front();
      rst  = rst_q.pop_front();
      got  = '{pc_write, if_id_write, if_id_flush, ID_EXE_flush, md_busy};
      tests_run++;
      if (got !== e) begin
         tests_failed++;
         $display("[TB] FAIL %s: outputs {pc,ifid_w,ifid_fl,idex_fl,busy} got %b want %b",
                  name, got, e);
      end
      tests_run++;
      if (stall_count !== exp_count) begin
         tests_failed++;
         $display("[TB] FAIL %s stall_count: got %0d want %0d", name, stall_count, exp_count);
      end
      if (!rst) begin
         exp_count = 16'd0;
      end else if (!e.pc_write && (exp_count != 16'hFFFF)) begin
         exp_count = exp_count + 16'd1;
      end
   endtask

   task automatic runCycle(input stim_t s, input exp_t e, input string name);
      applyStimulus(s, e, name);
      checkOutput();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      exp_count    = 16'd0;

      reset = 1'b0; mem_read_ex = 1'b0; rt_ex = '0; rs_id = '0; rt_id = '0;
      uses_rt_id = 1'b0; branch_taken_ex = 1'b0; md_start_id = 1'b0;
      repeat (2) @(posedge clock);

      vecs[0]  = '{mk(1,0, 0, 0, 0,0,0,0), NORMAL,   "normal"};
      vecs[1]  = '{mk(1,1, 5, 5, 0,0,0,0), STALL_LU, "lu_rs5"};
      vecs[2]  = '{mk(1,0, 0, 0, 0,0,0,0), NORMAL,   "after_lu"};
      vecs[3]  = '{mk(1,1, 9, 3, 9,1,0,0), STALL_LU, "lu_rt_used"};
      vecs[4]  = '{mk(1,1, 9, 3, 9,0,0,0), NORMAL,   "rt_not_used"};
      vecs[5]  = '{mk(1,1, 0, 0, 0,0,0,0), NORMAL,   "rs_zero"};
      vecs[6]  = '{mk(1,1, 0, 7, 0,1,0,0), NORMAL,   "rt_zero"};
      vecs[7]  = '{mk(1,0, 5, 5, 5,1,0,0), NORMAL,   "no_load"};
      vecs[8]  = '{mk(1,0, 0, 0, 0,0,1,0), BRANCH,   "branch"};
      vecs[9]  = '{mk(1,1, 6, 6, 0,0,1,0), BRANCH,   "branch_over_lu"};
      vecs[10] = '{mk(1,1,31,31, 0,0,0,0), STALL_LU, "lu_r31"};
      vecs[11] = '{mk(1,0, 0, 0, 0,0,1,1), BRANCH,   "branch_kills_md"};
      vecs[12] = '{mk(1,0, 0, 0, 0,0,0,0), NORMAL,   "idle_after_kill"};

      $display("[TB] reset state");
      runCycle(mk(0,0,0,0,0,0,0,0), RESET_O, "reset");

      $display("[TB] vector table");
      foreach (vecs[i]) runCycle(vecs[i].s, vecs[i].e, vecs[i].name);

      $display("[TB] mul/div stall of 8 cycles");
      runCycle(mk(1,0,0,0,0,0,0,1), STALL_MD, "md_start");
      for (int i = 0; i < 7; i++) runCycle(mk(1,0,0,0,0,0,0,0), STALL_MD, "md_wait");
      runCycle(mk(1,0,0,0,0,0,0,0), NORMAL, "md_done");

      $display("[TB] load-use and mul/div together");
      runCycle(mk(1,1,4,4,0,0,0,1), STALL_LU, "lu_before_md");
      runCycle(mk(1,0,0,0,0,0,0,1), STALL_MD, "md_after_lu");
      for (int i = 0; i < 7; i++) runCycle(mk(1,0,0,0,0,0,0,0), STALL_MD, "md_wait2");
      runCycle(mk(1,0,0,0,0,0,0,0), NORMAL, "md_done2");

      $display("[TB] branch on third MD_WAIT cycle");
      runCycle(mk(1,0,0,0,0,0,0,1), STALL_MD, "md_start3");
      for (int i = 0; i < 2; i++) runCycle(mk(1,0,0,0,0,0,0,0), STALL_MD, "md_wait3");
      runCycle(mk(1,0,0,0,0,0,1,0), BRANCH, "md_branch");
      runCycle(mk(1,0,0,0,0,0,0,0), NORMAL, "post_branch");
      runCycle(mk(1,0,0,0,0,0,0,0), NORMAL, "post_branch2");

      $display("[TB] reset during MD_WAIT");
      runCycle(mk(1,0,0,0,0,0,0,1), STALL_MD, "md_start4");
      for (int i = 0; i < 2; i++) runCycle(mk(1,0,0,0,0,0,0,0), STALL_MD, "md_wait4");
      for (int i = 0; i < 2; i++) runCycle(mk(0,0,0,0,0,0,0,0), RESET_O, "mid_reset");
      runCycle(mk(1,0,0,0,0,0,0,0), NORMAL, "post_reset");
      runCycle(mk(1,0,0,0,0,0,0,0), NORMAL, "post_reset2");

      $display("[TB] stall counter saturation");
      runCycle(mk(1,1,5,5,0,0,0,0), STALL_LU, "sat_first");
      for (int i = 0; i < 70000; i++) begin
         @(posedge clock);
         if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      end
      runCycle(mk(1,1,5,5,0,0,0,0), STALL_LU, "sat_hold");
      runCycle(mk(1,1,5,5,0,0,0,0), STALL_LU, "sat_nowrap");
      runCycle(mk(1,0,0,0,0,0,0,0), NORMAL, "sat_release");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
